fifo_push_arb: RTL and testbench

- Round-robin arbiter that shares the single push (in_*) interface of a fifo_gen instance among N_REQ producers.
- Zero-latency combinational forward path: selected requester's val/data drive out_* directly into the FIFO push port.
- A burst lock keeps one producer granted for up to MAX_BURST back-to-back beats.
- out_src tags each beat with its origin.

---
 rtl/fifo_push_arb.sv | 148 ++++++++++++++
 tb/tb_fifo_push_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arb.sv
// fifo_push_arb
//   Round-robin arbiter that shares one fifo_gen push port among N_REQ
//   producers. The forward path is purely combinational: the selected
//   requester's valid and data drive out_* in the same cycle. A burst lock
//   keeps one producer selected for up to MAX_BURST back-to-back beats, and a
//   hold register freezes the selection while the FIFO applies back-pressure.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   req_val      per-requester valid
//   req_rdy      per-requester ready (one-hot or zero)
//   req_data     requester i at bits [i*SIZE +: SIZE]
//   out_val      to FIFO in_val
//   out_rdy      from FIFO in_rdy
//   out_data     to FIFO in_data
//   out_src      index of the currently selected requester
//   lock_active  burst lock held (registered)
module fifo_push_arb #(
  parameter int N_REQ_IDX = 2,
  parameter int N_REQ     = 4,
  parameter int SIZE      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_val,
  output logic [N_REQ-1:0]        req_rdy,
  input  logic [N_REQ*SIZE-1:0]   req_data,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [SIZE-1:0]         out_data,
  output logic [N_REQ_IDX-1:0]    out_src,
  output logic                    lock_active
);

  // beat_cnt must be able to represent MAX_BURST itself
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_reg;
  logic [N_REQ_IDX-1:0]   rr_ptr_reg;
  logic [N_REQ_IDX-1:0]   owner_reg;
  logic [N_REQ_IDX-1:0]   hold_id_reg;
  logic [CW-1:0]          beat_cnt_reg;
  logic                   hold_reg;
  logic                   lock_active_reg;

  logic [SIZE-1:0]        data_arr [N_REQ];
  logic [N_REQ_IDX-1:0]   rr_sel;
  logic [N_REQ_IDX-1:0]   sel;
  logic [CW-1:0]          beat_inc;
  logic                   owner_valid;
  logic                   release_lock;
  logic                   xfer;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign data_arr[gi] = req_data[gi*SIZE +: SIZE];
      assign req_rdy[gi]  = rst_n && out_rdy && req_val[gi] &&
                            (sel == N_REQ_IDX'(gi));
    end
  endgenerate

  // Circular search from rr_ptr_reg; iterating from the far end downward lets
  // the nearest valid requester win. With no requester valid rr_sel stays at
  // rr_ptr_reg, whose valid is 0, so out_val is 0.
  always_comb begin
    rr_sel = rr_ptr_reg;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_val[rr_ptr_reg + N_REQ_IDX'(k)]) begin
        rr_sel = rr_ptr_reg + N_REQ_IDX'(k);
      end
    end
  end

  assign owner_valid  = req_val[owner_reg];
  // Owner went quiet with nothing stalled: drop the lock this very cycle so
  // round-robin can pick a new winner without a bubble.
  assign release_lock = (state_reg == LOCKED) && !hold_reg && !owner_valid;

  always_comb begin
    if (hold_reg) begin
      sel = hold_id_reg;
    end else if ((state_reg == LOCKED) && owner_valid) begin
      sel = owner_reg;
    end else begin
      sel = rr_sel;
    end
  end

  assign out_val     = rst_n && req_val[sel];
  assign out_data    = data_arr[sel];
  assign out_src     = sel;
  assign xfer        = out_val && out_rdy;
  assign beat_inc    = beat_cnt_reg + CW'(1);
  assign lock_active = lock_active_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      owner_reg       <= '0;
      hold_id_reg     <= '0;
      beat_cnt_reg    <= '0;
      hold_reg        <= 1'b0;
      lock_active_reg <= 1'b0;
    end else begin
      // A stalled beat pins the selection until it transfers
      hold_reg    <= out_val && !out_rdy;
      hold_id_reg <= sel;

      if ((state_reg == LOCKED) && !release_lock) begin
        // Inside a lock the selection is the owner, so any transfer is its beat
        if (xfer) begin
          if (beat_inc == MAX_CNT) begin
            state_reg       <= IDLE;
            lock_active_reg <= 1'b0;
            beat_cnt_reg    <= '0;
          end else begin
            beat_cnt_reg <= beat_inc;
          end
        end
      end else begin
        // Idle, or a lock released this cycle: arbitrate as round-robin
        if (xfer) begin
          rr_ptr_reg <= sel + 1'b1;
          if (MAX_BURST > 1) begin
            state_reg       <= LOCKED;
            lock_active_reg <= 1'b1;
            owner_reg       <= sel;
            beat_cnt_reg    <= CW'(1);
          end else begin
            state_reg       <= IDLE;
            lock_active_reg <= 1'b0;
          end
        end else begin
          state_reg       <= IDLE;
          lock_active_reg <= 1'b0;
          beat_cnt_reg    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Testbench for fifo_push_arb: two instances (MAX_BURST=4 and MAX_BURST=1),
// directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural arbiter model.
module tb_fifo_push_arb;

  localparam int NI = 2;
  localparam int N  = 4;
  localparam int SZ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [N-1:0]    req_val   [2];
  logic [N*SZ-1:0] req_data  [2];
  logic            out_rdy   [2];
  logic [N-1:0]    req_rdy   [2];
  logic            out_val   [2];
  logic [SZ-1:0]   out_data  [2];
  logic [NI-1:0]   out_src   [2];
  logic            lock_active [2];

  int n_checks = 0;
  int n_fail   = 0;

  fifo_push_arb #(.N_REQ_IDX(NI), .N_REQ(N), .SIZE(SZ), .MAX_BURST(4)) u_dut_b4 (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val[0]), .req_rdy(req_rdy[0]), .req_data(req_data[0]),
    .out_val(out_val[0]), .out_rdy(out_rdy[0]), .out_data(out_data[0]),
    .out_src(out_src[0]), .lock_active(lock_active[0])
  );

  fifo_push_arb #(.N_REQ_IDX(NI), .N_REQ(N), .SIZE(SZ), .MAX_BURST(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val[1]), .req_rdy(req_rdy[1]), .req_data(req_data[1]),
    .out_val(out_val[1]), .out_rdy(out_rdy[1]), .out_data(out_data[1]),
    .out_src(out_src[1]), .lock_active(lock_active[1])
  );

  always #5 clk = ~clk;

  function automatic int mb(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Locked: remaining beats in the current burst; next_rr: first index the
  // round-robin search looks at; pending: beat stalled by the FIFO.
  bit m_locked  [2];
  int m_owner   [2];
  int m_left    [2];
  int m_next    [2];
  bit m_pending [2];
  int m_pend_id [2];
  int wait_cnt  [2][N];

  int            s;
  bit            ev, xf, pend_old;
  logic [N-1:0]  erdy;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk($sformatf("dut%0d rst out_val", d), out_val[d], 0);
        chk($sformatf("dut%0d rst req_rdy", d), req_rdy[d], 0);
        chk($sformatf("dut%0d rst lock", d), lock_active[d], 0);
        m_locked[d] = 0; m_owner[d] = 0; m_left[d] = 0; m_next[d] = 0;
        m_pending[d] = 0; m_pend_id[d] = 0;
        for (int i = 0; i < N; i++) wait_cnt[d][i] = 0;
      end else begin
        // who must be selected this cycle
        if (m_pending[d]) s = m_pend_id[d];
        else if (m_locked[d] && req_val[d][m_owner[d]]) s = m_owner[d];
        else begin
          s = -1;
          for (int k = 0; k < N; k++) begin
            if (s < 0 && req_val[d][(m_next[d] + k) % N]) s = (m_next[d] + k) % N;
          end
        end
        ev   = (s >= 0) && req_val[d][s];
        xf   = ev && out_rdy[d];
        erdy = xf ? N'(1 << s) : '0;

        chk($sformatf("dut%0d lock_active", d), lock_active[d], m_locked[d]);
        chk($sformatf("dut%0d out_val", d), out_val[d], ev);
        chk($sformatf("dut%0d req_rdy", d), req_rdy[d], erdy);
        if (ev) begin
          chk($sformatf("dut%0d out_src", d), out_src[d], s);
          chk($sformatf("dut%0d out_data", d), out_data[d], req_data[d][s*SZ +: SZ]);
        end

        // fairness bound: transfers by others while a requester waits
        if (xf) chk($sformatf("dut%0d starve", d), wait_cnt[d][s] <= (N - 1) * mb(d), 1);
        for (int i = 0; i < N; i++) begin
          if (!req_val[d][i] || (xf && i == s)) wait_cnt[d][i] = 0;
          else if (xf) wait_cnt[d][i]++;
        end

        // advance the model
        pend_old      = m_pending[d];
        m_pending[d]  = ev && !out_rdy[d];
        m_pend_id[d]  = s;
        if (xf) begin
          if (m_locked[d] && s == m_owner[d]) begin
            m_left[d]--;
            if (m_left[d] == 0) m_locked[d] = 0;
          end else begin
            m_next[d] = (s + 1) % N;
            if (mb(d) > 1) begin
              m_locked[d] = 1; m_owner[d] = s; m_left[d] = mb(d) - 1;
            end else begin
              m_locked[d] = 0;
            end
          end
        end else if (m_locked[d] && !req_val[d][m_owner[d]] && !pend_old) begin
          m_locked[d] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      req_val[d] = '0;
      out_rdy[d] = 1'b1;
    end
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0; idle_all();
    tick(); rst_n = 1'b1; idle_all();
  endtask

  logic [SZ-1:0] t1_data [5];
  int            burst_exp [9];
  logic [N-1:0]  got [2];

  initial begin
    t1_data   = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    burst_exp = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int d = 0; d < 2; d++) begin
      req_val[d] = '0; req_data[d] = '0; out_rdy[d] = 1'b1; got[d] = '0;
    end
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Single requester, five beats, lock cycles through 4 then relocks
    for (int k = 0; k < 5; k++) begin
      tick();
      req_val[0] = 4'b0001; req_data[0] = {12'h000, t1_data[k]};
      settle();
      chk("single src", out_src[0], 0);
      chk("single data", out_data[0], t1_data[k]);
      chk("single lock", lock_active[0], (k >= 1 && k <= 3) ? 1 : 0);
    end
    tick(); req_val[0] = '0; settle();
    chk("single relocked", lock_active[0], 1);
    tick(); settle();
    chk("single released", lock_active[0], 0);

    // Burst lock on dut0, round-robin fairness on dut1 (MAX_BURST=1)
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tick();
      req_val[0] = 4'b0011; req_data[0] = 16'h4321;
      req_val[1] = (k < 6) ? 4'b1111 : 4'b0000; req_data[1] = 16'h4321;
      settle();
      chk("burst src", out_src[0], burst_exp[k]);
      chk("burst val", out_val[0], 1);
      if (k < 6) begin
        chk("rr src", out_src[1], k % 4);
        chk("rr data", out_data[1], (k % 4) + 1);
      end
    end
    tick(); idle_all();

    // Back-pressure: selection frozen on requester 2
    do_reset();
    req_data[0] = 16'h0509;
    tick(); req_val[0] = 4'b0100; out_rdy[0] = 1'b0; settle();
    chk("bp c1 src", out_src[0], 2);
    chk("bp c1 rdy", req_rdy[0], 0);
    tick(); req_val[0] = 4'b0101; settle();
    chk("bp c2 src", out_src[0], 2);
    chk("bp c2 data", out_data[0], 5);
    tick(); settle();
    chk("bp c3 src", out_src[0], 2);
    tick(); out_rdy[0] = 1'b1; settle();
    chk("bp c4 src", out_src[0], 2);
    chk("bp c4 rdy", req_rdy[0], 4'b0100);
    tick(); req_val[0] = 4'b0001; settle();
    chk("bp c5 src", out_src[0], 0);
    chk("bp c5 data", out_data[0], 9);
    tick(); idle_all();

    // Early release: owner 1 drops after two beats, requester 3 follows
    do_reset();
    req_data[0] = 16'h8020;
    tick(); req_val[0] = 4'b0010; settle();
    chk("er b1 src", out_src[0], 1);
    tick(); req_val[0] = 4'b1010; settle();
    chk("er b2 src", out_src[0], 1);
    chk("er b2 lock", lock_active[0], 1);
    tick(); req_val[0] = 4'b1000; settle();
    chk("er next src", out_src[0], 3);
    chk("er next val", out_val[0], 1);
    chk("er next data", out_data[0], 8);
    tick(); req_val[0] = '0; settle();
    chk("er relock", lock_active[0], 1);
    tick(); idle_all();

    // Reset in the middle of a burst
    do_reset();
    req_data[0] = 16'h7001;
    tick(); req_val[0] = 4'b0001; settle();
    tick(); settle();
    chk("rst pre lock", lock_active[0], 1);
    tick(); rst_n = 1'b0; settle();
    chk("rst out_val", out_val[0], 0);
    chk("rst req_rdy", req_rdy[0], 0);
    chk("rst lock", lock_active[0], 0);
    tick(); rst_n = 1'b1; req_val[0] = 4'b1000; settle();
    chk("rst after src", out_src[0], 3);
    chk("rst after lock", lock_active[0], 0);
    tick(); req_val[0] = 4'b0011; settle();
    chk("rst rr restart", out_src[0], 0);
    tick(); idle_all();

    // Randomized traffic obeying the requester hold-until-ready rule
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (!(req_val[d][i] && !got[d][i])) begin
            req_val[d][i] = ($urandom_range(0, 99) < 55);
            req_data[d][i*SZ +: SZ] = SZ'($urandom);
          end
        end
        out_rdy[d] = ($urandom_range(0, 99) < 70);
      end
      settle();
      for (int d = 0; d < 2; d++) got[d] = req_rdy[d];
    end

    tick(); idle_all();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
